// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle RISC-V main controller. It steps each instruction through
// FETCH/DECODE/EXECUTE/MEM/WB and drives the datapath selects and strobes for each state.
// It adds a mem_req/mem_ready handshake, a wait-state watchdog and a sticky ERROR state.
// Define MC_CTRL_LUI_EN to decode lui (0110111) through an EXECU state.
module mc_ctrl_fsm #(
  parameter int WAIT_W = 4,
  parameter int OP_W   = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] op,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            PCUpdate,
  output logic            Branch,
  output logic            IRWrite,
  output logic            RegWrite,
  output logic            MemWrite,
  output logic            AdrSrc,
  output logic [1:0]      ResultSrc,
  output logic [1:0]      ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic [2:0]      ImmSrc,
  output logic            error
);

  localparam logic [OP_W-1:0] OP_LW  = OP_W'(7'b0000011);
  localparam logic [OP_W-1:0] OP_SW  = OP_W'(7'b0100011);
  localparam logic [OP_W-1:0] OP_R   = OP_W'(7'b0110011);
  localparam logic [OP_W-1:0] OP_I   = OP_W'(7'b0010011);
  localparam logic [OP_W-1:0] OP_BEQ = OP_W'(7'b1100011);
  localparam logic [OP_W-1:0] OP_JAL = OP_W'(7'b1101111);
`ifdef MC_CTRL_LUI_EN
  localparam logic [OP_W-1:0] OP_LUI = OP_W'(7'b0110111);
`endif

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_EXECU, S_ERROR
  } state_t;

  // Per-state control word; fetch marks the strobes that wait for mem_ready.
  typedef struct packed {
    logic       fetch;
    logic       mem_req;
    logic       pcupdate;
    logic       branch;
    logic       irwrite;
    logic       regwrite;
    logic       memwrite;
    logic       adrsrc;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       err;
  } ctrl_t;

  state_t            state, nxt;
  ctrl_t             ctrl_q;
  logic [WAIT_W-1:0] wcnt;
  logic              timeout;
  logic [2:0]        imm;

  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.fetch = 1'b1; c.mem_req = 1'b1; c.pcupdate = 1'b1; c.irwrite = 1'b1;
                        c.alusrcb = 2'b10; c.resultsrc = 2'b10; end
      S_DECODE:   begin c.alusrca = 2'b01; c.alusrcb = 2'b01; end
      S_MEMADR:   begin c.alusrca = 2'b10; c.alusrcb = 2'b01; end
      S_MEMREAD:  begin c.mem_req = 1'b1; c.adrsrc = 1'b1; end
      S_MEMWB:    begin c.resultsrc = 2'b01; c.regwrite = 1'b1; end
      S_MEMWRITE: begin c.mem_req = 1'b1; c.adrsrc = 1'b1; c.memwrite = 1'b1; end
      S_EXECR:    begin c.alusrca = 2'b10; c.aluop = 2'b10; end
      S_EXECI:    begin c.alusrca = 2'b10; c.alusrcb = 2'b01; c.aluop = 2'b10; end
      S_ALUWB:    begin c.regwrite = 1'b1; end
      S_BEQ:      begin c.alusrca = 2'b10; c.aluop = 2'b01; c.branch = 1'b1; end
      S_JAL:      begin c.alusrca = 2'b01; c.alusrcb = 2'b10; c.pcupdate = 1'b1; end
      S_EXECU:    begin c.alusrca = 2'b11; c.alusrcb = 2'b01; end
      S_ERROR:    begin c.err = 1'b1; end
      default:    c = '0;
    endcase
    return c;
  endfunction

  // A waiting access times out when the counter is saturated and memory is still not ready.
  assign timeout = (wcnt == {WAIT_W{1'b1}}) && !mem_ready;

  // Next-state selection; op is only looked at in DECODE and MEMADR.
  always_comb begin
    nxt = state;
    case (state)
      S_FETCH:    nxt = mem_ready ? S_DECODE : (timeout ? S_ERROR : S_FETCH);
      S_DECODE: begin
        if (op == OP_LW || op == OP_SW) nxt = S_MEMADR;
        else if (op == OP_R)            nxt = S_EXECR;
        else if (op == OP_I)            nxt = S_EXECI;
        else if (op == OP_BEQ)          nxt = S_BEQ;
        else if (op == OP_JAL)          nxt = S_JAL;
`ifdef MC_CTRL_LUI_EN
        else if (op == OP_LUI)          nxt = S_EXECU;
`endif
        else                            nxt = S_ERROR;
      end
      S_MEMADR:   nxt = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  nxt = mem_ready ? S_MEMWB : (timeout ? S_ERROR : S_MEMREAD);
      S_MEMWRITE: nxt = mem_ready ? S_FETCH : (timeout ? S_ERROR : S_MEMWRITE);
      S_MEMWB:    nxt = S_FETCH;
      S_EXECR:    nxt = S_ALUWB;
      S_EXECI:    nxt = S_ALUWB;
      S_EXECU:    nxt = S_ALUWB;
      S_ALUWB:    nxt = S_FETCH;
      S_BEQ:      nxt = S_FETCH;
      S_JAL:      nxt = S_ALUWB;
      S_ERROR:    nxt = S_ERROR;
      default:    nxt = S_ERROR;
    endcase
  end

  // State, registered control word and watchdog; reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_FETCH;
      ctrl_q <= ctrl_of(S_FETCH);
      wcnt   <= '0;
    end else begin
      state  <= nxt;
      ctrl_q <= ctrl_of(nxt);
      if (ctrl_q.mem_req && !mem_ready) wcnt <= wcnt + WAIT_W'(1);
      else                              wcnt <= '0;
    end
  end

  // Immediate format straight from op; unknown opcodes give the I format.
  always_comb begin
    imm = 3'b000;
    case (op)
      OP_SW:   imm = 3'b001;
      OP_BEQ:  imm = 3'b010;
      OP_JAL:  imm = 3'b011;
`ifdef MC_CTRL_LUI_EN
      OP_LUI:  imm = 3'b100;
`endif
      default: imm = 3'b000;
    endcase
  end

  // Everything is forced low while reset is high; fetch strobes fire only on the ready cycle.
  assign mem_req   = ~reset & ctrl_q.mem_req;
  assign PCUpdate  = ~reset & ctrl_q.pcupdate & (~ctrl_q.fetch | mem_ready);
  assign IRWrite   = ~reset & ctrl_q.irwrite & mem_ready;
  assign Branch    = ~reset & ctrl_q.branch;
  assign RegWrite  = ~reset & ctrl_q.regwrite;
  assign MemWrite  = ~reset & ctrl_q.memwrite;
  assign AdrSrc    = ~reset & ctrl_q.adrsrc;
  assign ResultSrc = ctrl_q.resultsrc & {2{~reset}};
  assign ALUSrcA   = ctrl_q.alusrca & {2{~reset}};
  assign ALUSrcB   = ctrl_q.alusrcb & {2{~reset}};
  assign ALUOp     = ctrl_q.aluop & {2{~reset}};
  assign ImmSrc    = imm & {3{~reset}};
  assign error     = ~reset & ctrl_q.err;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: an instruction-plan model (queue of pending phases) predicts all outputs.
// Every cycle is compared, with directed literal checks for latency, watchdog and decode cases.
// Honours MC_CTRL_LUI_EN when it is defined for the build.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, PCUpdate, Branch, IRWrite, RegWrite, MemWrite, AdrSrc, error;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;

  mc_ctrl_fsm #(.WAIT_W(4), .OP_W(7)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req), .PCUpdate(PCUpdate), .Branch(Branch), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic mem_req, pcupdate, branch, irwrite, regwrite, memwrite, adrsrc;
    logic [1:0] resultsrc, alusrca, alusrcb, aluop;
    logic [2:0] immsrc;
    logic error;
  } obs_t;

  typedef enum int {PH_FETCH, PH_DECODE, PH_MEMADR, PH_MEMREAD, PH_MEMWB, PH_MEMWRITE,
                    PH_EXECR, PH_EXECI, PH_ALUWB, PH_BEQ, PH_JAL, PH_EXECU} ph_t;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
  localparam logic [6:0] BEQ = 7'b1100011, JAL = 7'b1101111, LUI = 7'b0110111;
  localparam int WD_LIMIT = 15;  // 2**WAIT_W - 1

  ph_t  plan[$];
  bit   m_err = 1'b0;
  int   m_wait = 0;
  int   n_cmp = 0, n_bad = 0;
  obs_t seen;

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    if (o == SW)  return 3'b001;
    if (o == BEQ) return 3'b010;
    if (o == JAL) return 3'b011;
`ifdef MC_CTRL_LUI_EN
    if (o == LUI) return 3'b100;
`endif
    return 3'b000;
  endfunction

  function automatic bit is_mem(input ph_t p);
    return (p == PH_FETCH) || (p == PH_MEMREAD) || (p == PH_MEMWRITE);
  endfunction

  // Expected outputs for the phase at the head of the plan.
  function automatic obs_t expect_obs(input logic rst, input logic [6:0] o, input logic rdy);
    obs_t e;
    e = '0;
    if (rst) return e;
    e.immsrc = imm_of(o);
    if (m_err) begin e.error = 1'b1; return e; end
    case (plan[0])
      PH_FETCH:    begin e.mem_req = 1; e.irwrite = rdy; e.pcupdate = rdy; e.alusrcb = 2; e.resultsrc = 2; end
      PH_DECODE:   begin e.alusrca = 1; e.alusrcb = 1; end
      PH_MEMADR:   begin e.alusrca = 2; e.alusrcb = 1; end
      PH_MEMREAD:  begin e.mem_req = 1; e.adrsrc = 1; end
      PH_MEMWB:    begin e.resultsrc = 1; e.regwrite = 1; end
      PH_MEMWRITE: begin e.mem_req = 1; e.adrsrc = 1; e.memwrite = 1; end
      PH_EXECR:    begin e.alusrca = 2; e.aluop = 2; end
      PH_EXECI:    begin e.alusrca = 2; e.alusrcb = 1; e.aluop = 2; end
      PH_ALUWB:    begin e.regwrite = 1; end
      PH_BEQ:      begin e.alusrca = 2; e.aluop = 1; e.branch = 1; end
      PH_JAL:      begin e.alusrca = 1; e.alusrcb = 2; e.pcupdate = 1; end
      PH_EXECU:    begin e.alusrca = 3; e.alusrcb = 1; end
      default:     e = '0;
    endcase
    return e;
  endfunction

  // Advance the plan by one clock edge.
  task automatic model_step(input logic rst, input logic [6:0] o, input logic rdy);
    ph_t ph;
    if (rst) begin plan.delete(); plan.push_back(PH_FETCH); m_err = 0; m_wait = 0; return; end
    if (m_err) return;
    if (is_mem(plan[0]) && !rdy) begin
      if (m_wait == WD_LIMIT) begin m_err = 1; plan.delete(); end
      else m_wait++;
      return;
    end
    m_wait = 0;
    ph = plan.pop_front();
    case (ph)
      PH_FETCH: plan.push_back(PH_DECODE);
      PH_DECODE: begin
        if (o == LW || o == SW) plan.push_back(PH_MEMADR);
        else if (o == RT)  begin plan.push_back(PH_EXECR); plan.push_back(PH_ALUWB); end
        else if (o == IT)  begin plan.push_back(PH_EXECI); plan.push_back(PH_ALUWB); end
        else if (o == BEQ) plan.push_back(PH_BEQ);
        else if (o == JAL) begin plan.push_back(PH_JAL); plan.push_back(PH_ALUWB); end
`ifdef MC_CTRL_LUI_EN
        else if (o == LUI) begin plan.push_back(PH_EXECU); plan.push_back(PH_ALUWB); end
`endif
        else m_err = 1;
      end
      PH_MEMADR: begin
        if (o == LW) begin plan.push_back(PH_MEMREAD); plan.push_back(PH_MEMWB); end
        else plan.push_back(PH_MEMWRITE);
      end
      default: ;
    endcase
    if (m_err) plan.delete();
    else if (plan.size() == 0) plan.push_back(PH_FETCH);
  endtask

  // One clock: drive at negedge, compare 1ns later, step the model on the rising edge.
  task automatic cyc(input logic rst, input logic [6:0] o, input logic rdy);
    obs_t e;
    @(negedge clk);
    reset = rst; op = o; mem_ready = rdy;
    #1;
    seen = {mem_req, PCUpdate, Branch, IRWrite, RegWrite, MemWrite, AdrSrc,
            ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, error};
    e = expect_obs(rst, o, rdy);
    n_cmp++;
    if (seen !== e) begin
      n_bad++;
      $display("FAIL outputs t=%0t rst=%b op=%b rdy=%b: got %b expected %b", $time, rst, o, rdy, seen, e);
    end
    @(posedge clk);
    model_step(rst, o, rdy);
  endtask

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // Cycles from a DECODE up to and including the next fetch that writes IR.
  task automatic measure(input logic [6:0] o, output int n);
    n = 0;
    do begin cyc(1'b0, o, 1'b1); n++; end while (!seen.irwrite && n < 20);
  endtask

  logic [6:0] ops[7] = '{LW, SW, RT, IT, BEQ, JAL, LUI};

  initial begin
    int n;
    int rdy_pct;
    logic [6:0] o;
    logic r;
    plan.push_back(PH_FETCH);

    // Reset, then an R-type with memory always ready.
    cyc(1, RT, 1); chk("rst0_outputs", int'(seen), 0);
    cyc(1, RT, 1); chk("rst1_outputs", int'(seen), 0);
    cyc(0, RT, 1); chk("r_fetch_ir_pc", {seen.irwrite, seen.pcupdate}, 3);
    cyc(0, RT, 1); chk("r_decode_srca", seen.alusrca, 1);
    cyc(0, RT, 1); chk("r_execr_aluop", seen.aluop, 2);
    cyc(0, RT, 1); chk("r_aluwb_regwrite", seen.regwrite, 1);
    // lw with three not-ready cycles in MEMREAD.
    cyc(0, LW, 1); chk("lw_fetch", seen.irwrite, 1);
    cyc(0, LW, 1);
    cyc(0, LW, 1); chk("lw_memadr_srca", seen.alusrca, 2);
    for (int i = 0; i < 3; i++) begin
      cyc(0, LW, 0); chk("lw_wait_req_adr", {seen.mem_req, seen.adrsrc, seen.irwrite}, 6);
    end
    cyc(0, LW, 1); chk("lw_ready_req", seen.mem_req, 1);
    cyc(0, LW, 1); chk("lw_memwb", {seen.regwrite, seen.resultsrc}, 5);
    // sw: one MEMWRITE cycle then straight back to FETCH.
    cyc(0, SW, 1); chk("sw_fetch", seen.irwrite, 1);
    cyc(0, SW, 1);
    cyc(0, SW, 1);
    cyc(0, SW, 1); chk("sw_memwrite", {seen.memwrite, seen.adrsrc}, 3);
    cyc(0, BEQ, 1); chk("sw_back_to_fetch", {seen.irwrite, seen.regwrite}, 2);
    // beq.
    cyc(0, BEQ, 1);
    cyc(0, BEQ, 1); chk("beq_branch_aluop", {seen.branch, seen.aluop}, 5);
    cyc(0, RT, 1); chk("beq_fetch", seen.irwrite, 1);
    // Latencies with memory ready on the first request.
    measure(LW, n);  chk("lat_lw", n, 5);
    measure(SW, n);  chk("lat_sw", n, 4);
    measure(RT, n);  chk("lat_rtype", n, 4);
    measure(IT, n);  chk("lat_itype", n, 4);
    measure(JAL, n); chk("lat_jal", n, 4);
    measure(BEQ, n); chk("lat_beq", n, 3);
    // lui from DECODE.
    cyc(0, LUI, 1);
`ifdef MC_CTRL_LUI_EN
    chk("lui_imm", seen.immsrc, 4);
    cyc(0, LUI, 1); chk("lui_execu_srca", seen.alusrca, 3);
    cyc(0, LUI, 1); chk("lui_regwrite", seen.regwrite, 1);
`else
    chk("lui_imm", seen.immsrc, 0);
    cyc(0, LUI, 1); chk("lui_error", seen.error, 1);
`endif

    // Watchdog expiry in FETCH.
    cyc(1, RT, 0);
    n = 0;
    cyc(0, RT, 0);
    while (!seen.error && n < 40) begin n++; cyc(0, RT, 0); end
    chk("wd_wait_cycles", n, 16);
    for (int i = 0; i < 3; i++) begin
      cyc(0, RT, 1); chk("wd_error_sticky", {seen.error, seen.mem_req, seen.irwrite}, 4);
    end
    cyc(1, RT, 1); chk("wd_reset_clears", int'(seen), 0);
    cyc(0, RT, 1); chk("wd_refetch", {seen.irwrite, seen.error}, 2);
    // Ready arriving exactly at the timeout cycle wins.
    cyc(1, RT, 0);
    for (int i = 0; i < 15; i++) cyc(0, RT, 0);
    cyc(0, RT, 1); chk("wd_boundary_ready", {seen.irwrite, seen.error}, 2);
    cyc(0, RT, 1); chk("wd_boundary_decode", {seen.error, seen.alusrca}, 1);

    // Randomized traffic; op changes every cycle, memory latency varies per segment.
    rdy_pct = 100;
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) begin
        case ($urandom_range(0, 3))
          0: rdy_pct = 100;
          1: rdy_pct = 70;
          2: rdy_pct = 25;
          default: rdy_pct = 8;
        endcase
      end
      r = ($urandom_range(0, 99) < (m_err ? 20 : 1));
      if ($urandom_range(0, 9) == 0) o = 7'($urandom);
      else o = ops[$urandom_range(0, 6)];
      cyc(r, o, ($urandom_range(0, 99) < rdy_pct));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
